// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IF/LS requester and unified memory port bundle
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_rvld;
  logic              if_stall;
  logic                ls_req;
  logic                ls_we;
  logic [DATA_W/8-1:0] ls_wstrb;
  logic [ADDR_W-1:0]   ls_addr;
  logic [DATA_W-1:0]   ls_wdata;
  logic [DATA_W-1:0]   ls_rdata;
  logic                ls_rvld;
  logic                ls_stall;
  logic                mem_req;
  logic                mem_we;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_ready;
  logic [DATA_W-1:0]   mem_rdata;
  logic                mem_rvld;
  modport slave (
    input  if_req, if_addr, if_flush, ls_req, ls_we, ls_wstrb, ls_addr, ls_wdata,
           mem_ready, mem_rdata, mem_rvld,
    output if_rdata, if_rvld, if_stall, ls_rdata, ls_rvld, ls_stall,
           mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, if_flush, ls_req, ls_we, ls_wstrb, ls_addr, ls_wdata,
           mem_ready, mem_rdata, mem_rvld,
    input  if_rdata, if_rvld, if_stall, ls_rdata, ls_rvld, ls_stall,
           mem_req, mem_we, mem_wstrb, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-outstanding IF/LS arbiter for a unified memory port; MEM_ARB_RR_EN selects round-robin
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t              r_state, w_next;
  logic                r_owner_ls, r_drop, r_we;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                w_if_ok, w_grant_ls, w_grant, w_resp;
  assign w_if_ok = bus.if_req & ~bus.if_flush;
  assign w_grant = (r_state == IDLE) & (bus.ls_req | w_if_ok);
`ifdef MEM_ARB_RR_EN
  logic r_last_ls;
  assign w_grant_ls = bus.ls_req & (~w_if_ok | ~r_last_ls);
  // remember who won the most recent grant so contention alternates
  always_ff @(posedge clk)
    if (rst) r_last_ls <= 1'b0;
    else if (w_grant) r_last_ls <= w_grant_ls;
`else
  assign w_grant_ls = bus.ls_req;
`endif
  assign bus.mem_we    = r_we;
  assign bus.mem_wstrb = r_wstrb;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  // state register
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  // next state, response routing and stalls
  always_comb begin
    w_next = (w_grant) ? REQ :
             (r_state == REQ && bus.mem_ready) ? RESP :
             (r_state == RESP && bus.mem_rvld) ? IDLE : r_state;
    w_resp       = (r_state == RESP) & bus.mem_rvld;
    bus.mem_req  = (r_state == REQ);
    bus.if_rvld  = w_resp & ~r_owner_ls & ~r_drop & ~bus.if_flush;
    bus.ls_rvld  = w_resp & r_owner_ls;
    bus.if_rdata = bus.mem_rdata;
    bus.ls_rdata = r_we ? '0 : bus.mem_rdata;
    bus.if_stall = bus.if_req & ~bus.if_rvld & ~bus.if_flush;
    bus.ls_stall = bus.ls_req & ~bus.ls_rvld;
  end
  // latch the winner's request fields at grant; IF carries no write data
  always_ff @(posedge clk)
    if (rst) begin
      r_owner_ls <= 1'b0;
      r_we       <= 1'b0;
      r_wstrb    <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else if (w_grant) begin
      r_owner_ls <= w_grant_ls;
      r_we       <= w_grant_ls & bus.ls_we;
      r_wstrb    <= w_grant_ls ? bus.ls_wstrb : '0;
      r_addr     <= w_grant_ls ? bus.ls_addr : bus.if_addr;
      r_wdata    <= w_grant_ls ? bus.ls_wdata : '0;
    end
  // a flushed fetch still completes on memory but its response is swallowed
  always_ff @(posedge clk)
    if (rst || w_resp) r_drop <= 1'b0;
    else if ((r_state != IDLE) && !r_owner_ls && bus.if_flush) r_drop <= 1'b1;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table, random run against a transaction model, grant-order sequence
module tb_mem_port_arbiter;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int n_tests = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  logic        c_rst, c_ifr, c_fl, c_lsr, c_we, c_rdy, c_rv;
  logic [3:0]  c_wstrb;
  logic [31:0] c_ifa, c_la, c_wd, c_rdat;
  task automatic drive();
    rst = c_rst;
    bus.if_req = c_ifr; bus.if_addr = c_ifa; bus.if_flush = c_fl;
    bus.ls_req = c_lsr; bus.ls_we = c_we; bus.ls_wstrb = c_wstrb;
    bus.ls_addr = c_la; bus.ls_wdata = c_wd;
    bus.mem_ready = c_rdy; bus.mem_rvld = c_rv; bus.mem_rdata = c_rdat;
  endtask
  typedef struct {
    logic rst, ifr; logic [31:0] ifa; logic fl, lsr, we; logic [31:0] la, wd;
    logic rdy, rv; logic [31:0] rdat;
    logic mreq; logic [31:0] maddr; logic mwe, ifv, lsv, ifs, lss; logic [31:0] rd;
  } vec_t;
  vec_t vq[$];
  // transaction-level reference: one in-flight record plus an accepted flag
  bit          m_busy, m_acc, m_ls, m_drop, m_we, m_last_ls;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata;
  bit          outst;
  initial begin
    c_rst = 1; {c_ifr, c_fl, c_lsr, c_we, c_rdy, c_rv} = '0;
    c_wstrb = '0; {c_ifa, c_la, c_wd, c_rdat} = '0;
    drive();
    repeat (2) @(posedge clk);
    //          rst ifr ifa         fl lsr we la          wd            rdy rv rdat          mreq maddr      mwe ifv lsv ifs lss rd
    vq.push_back('{1, 0, 32'h0,      0, 0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        0, 32'h0,    0, 0, 0, 0, 0, 32'h0});
    vq.push_back('{0, 1, 32'h100,    0, 0, 0, 32'h0,    32'h0,        1, 0, 32'h0,        0, 32'h0,    0, 0, 0, 1, 0, 32'h0});
    vq.push_back('{0, 1, 32'h100,    0, 0, 0, 32'h0,    32'h0,        1, 0, 32'h0,        1, 32'h100,  0, 0, 0, 1, 0, 32'h0});
    vq.push_back('{0, 1, 32'h100,    0, 0, 0, 32'h0,    32'h0,        1, 1, 32'h00500093, 0, 32'h100,  0, 1, 0, 0, 0, 32'h00500093});
    vq.push_back('{0, 0, 32'h0,      0, 0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        0, 32'h100,  0, 0, 0, 0, 0, 32'h0});
    vq.push_back('{0, 1, 32'h104,    0, 1, 1, 32'h2000, 32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h100,  0, 0, 0, 1, 1, 32'h0});
    vq.push_back('{0, 1, 32'h104,    0, 1, 1, 32'h2000, 32'hDEADBEEF, 1, 0, 32'h0,        1, 32'h2000, 1, 0, 0, 1, 1, 32'h0});
    vq.push_back('{0, 1, 32'h104,    0, 1, 1, 32'h2000, 32'hDEADBEEF, 0, 1, 32'h12345678, 0, 32'h2000, 1, 0, 1, 1, 0, 32'h0});
    vq.push_back('{0, 1, 32'h104,    0, 0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        0, 32'h2000, 1, 0, 0, 1, 0, 32'h0});
    vq.push_back('{0, 1, 32'h104,    0, 0, 0, 32'h0,    32'h0,        1, 0, 32'h0,        1, 32'h104,  0, 0, 0, 1, 0, 32'h0});
    vq.push_back('{0, 1, 32'h104,    0, 0, 0, 32'h0,    32'h0,        0, 1, 32'hAAAA0001, 0, 32'h104,  0, 1, 0, 0, 0, 32'hAAAA0001});
    vq.push_back('{0, 1, 32'h200,    0, 0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        0, 32'h104,  0, 0, 0, 1, 0, 32'h0});
    vq.push_back('{0, 1, 32'h200,    0, 0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        1, 32'h200,  0, 0, 0, 1, 0, 32'h0});
    vq.push_back('{0, 1, 32'h200,    0, 0, 0, 32'h0,    32'h0,        0, 1, 32'h00000BAD, 1, 32'h200,  0, 0, 0, 1, 0, 32'h0});
    vq.push_back('{0, 1, 32'h200,    0, 0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        1, 32'h200,  0, 0, 0, 1, 0, 32'h0});
    vq.push_back('{0, 1, 32'h200,    0, 0, 0, 32'h0,    32'h0,        1, 0, 32'h0,        1, 32'h200,  0, 0, 0, 1, 0, 32'h0});
    vq.push_back('{0, 1, 32'h200,    0, 0, 0, 32'h0,    32'h0,        0, 1, 32'h11112222, 0, 32'h200,  0, 1, 0, 0, 0, 32'h11112222});
    vq.push_back('{0, 1, 32'h204,    0, 0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        0, 32'h200,  0, 0, 0, 1, 0, 32'h0});
    vq.push_back('{0, 1, 32'h204,    0, 0, 0, 32'h0,    32'h0,        1, 0, 32'h0,        1, 32'h204,  0, 0, 0, 1, 0, 32'h0});
    vq.push_back('{0, 1, 32'h204,    1, 0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        0, 32'h204,  0, 0, 0, 0, 0, 32'h0});
    vq.push_back('{0, 1, 32'h300,    0, 0, 0, 32'h0,    32'h0,        0, 1, 32'hBADBAD00, 0, 32'h204,  0, 0, 0, 1, 0, 32'h0});
    vq.push_back('{0, 1, 32'h300,    0, 0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        0, 32'h204,  0, 0, 0, 1, 0, 32'h0});
    vq.push_back('{0, 1, 32'h300,    0, 0, 0, 32'h0,    32'h0,        1, 0, 32'h0,        1, 32'h300,  0, 0, 0, 1, 0, 32'h0});
    vq.push_back('{0, 1, 32'h300,    0, 0, 0, 32'h0,    32'h0,        0, 1, 32'h0000300D, 0, 32'h300,  0, 1, 0, 0, 0, 32'h0000300D});
    vq.push_back('{0, 1, 32'h400,    1, 0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        0, 32'h300,  0, 0, 0, 0, 0, 32'h0});
    vq.push_back('{0, 0, 32'h0,      0, 0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        0, 32'h300,  0, 0, 0, 0, 0, 32'h0});
    vq.push_back('{0, 0, 32'h0,      0, 1, 0, 32'h2004, 32'h0,        0, 0, 32'h0,        0, 32'h300,  0, 0, 0, 0, 1, 32'h0});
    vq.push_back('{0, 0, 32'h0,      0, 1, 0, 32'h2004, 32'h0,        1, 0, 32'h0,        1, 32'h2004, 0, 0, 0, 0, 1, 32'h0});
    vq.push_back('{1, 0, 32'h0,      0, 1, 0, 32'h2004, 32'h0,        0, 0, 32'h0,        0, 32'h2004, 0, 0, 0, 0, 1, 32'h0});
    vq.push_back('{0, 0, 32'h0,      0, 0, 0, 32'h0,    32'h0,        0, 1, 32'h00000055, 0, 32'h0,    0, 0, 0, 0, 0, 32'h0});
    vq.push_back('{0, 1, 32'h500,    0, 0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        0, 32'h0,    0, 0, 0, 1, 0, 32'h0});
    vq.push_back('{0, 1, 32'h500,    0, 0, 0, 32'h0,    32'h0,        1, 0, 32'h0,        1, 32'h500,  0, 0, 0, 1, 0, 32'h0});
    vq.push_back('{0, 1, 32'h500,    1, 0, 0, 32'h0,    32'h0,        0, 1, 32'h00000077, 0, 32'h500,  0, 0, 0, 0, 0, 32'h0});
    vq.push_back('{0, 1, 32'h504,    0, 0, 0, 32'h0,    32'h0,        0, 0, 32'h0,        0, 32'h500,  0, 0, 0, 1, 0, 32'h0});
    vq.push_back('{0, 1, 32'h504,    0, 0, 0, 32'h0,    32'h0,        1, 0, 32'h0,        1, 32'h504,  0, 0, 0, 1, 0, 32'h0});
    vq.push_back('{0, 1, 32'h504,    0, 0, 0, 32'h0,    32'h0,        0, 1, 32'h00000088, 0, 32'h504,  0, 1, 0, 0, 0, 32'h00000088});
    foreach (vq[i]) begin
      vec_t t;
      t = vq[i];
      @(posedge clk); #1;
      c_rst = t.rst; c_ifr = t.ifr; c_ifa = t.ifa; c_fl = t.fl; c_lsr = t.lsr; c_we = t.we;
      c_la = t.la; c_wd = t.wd; c_wstrb = t.lsr ? 4'hF : 4'h0;
      c_rdy = t.rdy; c_rv = t.rv; c_rdat = t.rdat;
      drive();
      #3;
      chk($sformatf("v%0d mem_req", i), bus.mem_req, t.mreq);
      chk($sformatf("v%0d mem_addr", i), bus.mem_addr, t.maddr);
      chk($sformatf("v%0d mem_we", i), bus.mem_we, t.mwe);
      chk($sformatf("v%0d if_rvld", i), bus.if_rvld, t.ifv);
      chk($sformatf("v%0d ls_rvld", i), bus.ls_rvld, t.lsv);
      chk($sformatf("v%0d if_stall", i), bus.if_stall, t.ifs);
      chk($sformatf("v%0d ls_stall", i), bus.ls_stall, t.lss);
      if (t.ifv) chk($sformatf("v%0d if_rdata", i), bus.if_rdata, t.rd);
      if (t.lsv) chk($sformatf("v%0d ls_rdata", i), bus.ls_rdata, t.rd);
    end
    @(posedge clk); #1;
    c_rst = 1; {c_ifr, c_fl, c_lsr, c_we, c_rdy, c_rv} = '0;
    drive();
    @(posedge clk);
    {m_busy, m_acc, m_ls, m_drop, m_we, m_last_ls, outst} = '0;
    m_wstrb = '0; m_addr = '0; m_wdata = '0;
    c_rst = 0;
    for (int n = 0; n < 4000; n++) begin
      bit e_req, resp, e_ifv, e_lsv, if_ok, gls;
      #1; drive();
      #3;
      e_req = m_busy & ~m_acc;
      resp  = m_busy & m_acc & c_rv;
      e_ifv = resp & ~m_ls & ~m_drop & ~c_fl;
      e_lsv = resp & m_ls;
      chk("rnd mem_req", bus.mem_req, e_req);
      chk("rnd mem_addr", bus.mem_addr, m_addr);
      chk("rnd mem_we", bus.mem_we, m_we);
      chk("rnd mem_wstrb", bus.mem_wstrb, m_wstrb);
      chk("rnd mem_wdata", bus.mem_wdata, m_wdata);
      chk("rnd if_rvld", bus.if_rvld, e_ifv);
      chk("rnd ls_rvld", bus.ls_rvld, e_lsv);
      chk("rnd if_stall", bus.if_stall, c_ifr & ~e_ifv & ~c_fl);
      chk("rnd ls_stall", bus.ls_stall, c_lsr & ~e_lsv);
      if (e_ifv) chk("rnd if_rdata", bus.if_rdata, c_rdat);
      if (e_lsv) chk("rnd ls_rdata", bus.ls_rdata, m_we ? 32'h0 : c_rdat);
      if_ok = c_ifr & ~c_fl;
      if (c_rst) begin
        {m_busy, m_acc, m_ls, m_drop, m_we, m_last_ls} = '0;
        m_wstrb = '0; m_addr = '0; m_wdata = '0;
      end else if (!m_busy) begin
        if (c_lsr || if_ok) begin
          gls = c_lsr && !(if_ok && RR && m_last_ls);
          m_busy = 1; m_acc = 0; m_drop = 0; m_ls = gls; m_last_ls = gls;
          m_addr = gls ? c_la : c_ifa; m_we = gls & c_we;
          m_wstrb = gls ? c_wstrb : 4'h0; m_wdata = gls ? c_wd : 32'h0;
        end
      end else if (!m_acc) begin
        if (c_rdy) m_acc = 1;
        if (c_fl && !m_ls) m_drop = 1;
      end else if (c_rv) m_busy = 0;
      else if (c_fl && !m_ls) m_drop = 1;
      if (c_rst) outst = 0;
      else if (bus.mem_req && c_rdy) outst = 1;
      if (c_rst || !c_ifr || e_ifv || c_fl) begin
        c_ifr = ($urandom_range(0, 2) != 0); c_ifa = {22'h0, 8'($urandom()), 2'b00};
      end
      if (c_rst || !c_lsr || e_lsv) begin
        c_lsr = 1'($urandom()); c_we = 1'($urandom()); c_wstrb = 4'($urandom());
        c_la = {16'h0, 14'($urandom()), 2'b00}; c_wd = $urandom();
      end
      c_fl = ($urandom_range(0, 9) == 0);
      c_rdy = 1'($urandom());
      if (outst) begin c_rv = 1'($urandom()); if (c_rv) outst = 0; end
      else c_rv = ($urandom_range(0, 7) == 0);
      c_rdat = $urandom();
      c_rst = ($urandom_range(0, 199) == 0);
      @(posedge clk);
    end
    #1;
    c_rst = 1; {c_fl, c_we, c_rv} = '0; c_ifr = 1; c_lsr = 1; c_rdy = 1;
    c_ifa = 32'h4000; c_la = 32'h3000; c_wstrb = 4'hF;
    drive();
    @(posedge clk); #1;
    c_rst = 0; drive();
    begin
      logic [31:0] order[4];
      int ng = 0;
      bit acc = 0;
      for (int k = 0; k < 30; k++) begin
        if (k > 0) begin @(posedge clk); #1; end
        c_rv = acc; drive();
        #3;
        acc = bus.mem_req;
        if (acc && ng < 4) begin order[ng] = bus.mem_addr; ng++; end
      end
      chk("grant count", ng, 4);
      for (int k = 0; k < 4; k++)
        chk($sformatf("grant %0d addr", k), order[k], (RR && k % 2 == 1) ? 32'h4000 : 32'h3000);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
